// File: rtl/matrix_scan_sched.sv
// matrix_scan_sched: HUB75-style LED matrix scan scheduler.
// Generates column reads, shift clock, row latch and BCM-weighted OE timing.
//
// Ports:
//   clk_in       single rising-edge clock
//   rstb         synchronous active-low reset
//   enable       run the scan while high
//   column_addr  framebuffer column read address
//   rd_en        framebuffer read strobe (data valid one cycle later)
//   bitplane     current BCM plane (selects the pixel data bit)
//   row_addr     panel row address
//   clk_pixel    panel shift clock
//   row_latch    panel latch strobe
//   oe_n         panel output enable, active-low
//   frame_done   one-cycle pulse on the last DISPLAY cycle of a frame
//   dim          (SCAN_DIM_EN only) brightness right-shift, taken on DISPLAY entry
//
// Optional feature macro: SCAN_DIM_EN adds the dim[1:0] input.
// OE_BASE_TICKS must be at least 8 so the dimmed display length is never 0.

module matrix_scan_sched #(
    parameter int PIXEL_WIDTH      = 64,
    parameter int PIXEL_HALFHEIGHT = 16,
    parameter int BRIGHTNESS_BITS  = 4,
    parameter int OE_BASE_TICKS    = 16
) (
    input  logic                               clk_in,
    input  logic                               rstb,
    input  logic                               enable,
    output logic [$clog2(PIXEL_WIDTH)-1:0]     column_addr,
    output logic                               rd_en,
    output logic [$clog2(BRIGHTNESS_BITS)-1:0] bitplane,
    output logic [3:0]                         row_addr,
    output logic                               clk_pixel,
    output logic                               row_latch,
    output logic                               oe_n,
    output logic                               frame_done
`ifdef SCAN_DIM_EN
    ,
    input  logic [1:0]                         dim
`endif
);

    localparam int COLW = $clog2(PIXEL_WIDTH);
    localparam int BPW  = $clog2(BRIGHTNESS_BITS);
    // Sized to hold the longest (last-plane) display period.
    localparam int CW   = $clog2((OE_BASE_TICKS << (BRIGHTNESS_BITS - 1)) + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t          state, state_d;
    logic [COLW-1:0] col, col_d;
    logic            phase, phase_d;
    logic [BPW-1:0]  bp, bp_d;
    logic [3:0]      scan_row, scan_row_d;
    logic [3:0]      row_q, row_q_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [CW-1:0]   disp_len;
    logic [1:0]      dim_v;
    logic            last_plane;
    logic            last_row;

    always_ff @(posedge clk_in) begin
        if (!rstb) begin
            state    <= IDLE;
            col      <= '0;
            phase    <= 1'b0;
            bp       <= '0;
            scan_row <= '0;
            row_q    <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_d;
            col      <= col_d;
            phase    <= phase_d;
            bp       <= bp_d;
            scan_row <= scan_row_d;
            row_q    <= row_q_d;
            cnt      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        col_d      = col;
        phase_d    = phase;
        bp_d       = bp;
        scan_row_d = scan_row;
        row_q_d    = row_q;
        cnt_d      = cnt;
        rd_en      = 1'b0;
        clk_pixel  = 1'b0;
        row_latch  = 1'b0;
        oe_n       = 1'b1;
        frame_done = 1'b0;

`ifdef SCAN_DIM_EN
        dim_v = dim;
`else
        dim_v = 2'd0;
`endif
        // dim is only consumed in LATCH, i.e. on the edge entering DISPLAY.
        disp_len   = (CW'(OE_BASE_TICKS) << bp) >> dim_v;
        last_plane = (bp == BPW'(BRIGHTNESS_BITS - 1));
        last_row   = (scan_row == 4'(PIXEL_HALFHEIGHT - 1));

        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_d = SHIFT;
                    col_d   = '0;
                    phase_d = 1'b0;
                end
            end
            SHIFT: begin
                if (!phase) begin
                    rd_en   = 1'b1;
                    phase_d = 1'b1;
                end else begin
                    clk_pixel = 1'b1;
                    phase_d   = 1'b0;
                    if (col == COLW'(PIXEL_WIDTH - 1)) begin
                        col_d   = '0;
                        row_q_d = scan_row;
                        state_d = BLANK;
                    end else begin
                        col_d = col + 1'b1;
                    end
                end
            end
            BLANK: begin
                state_d = LATCH;
            end
            LATCH: begin
                row_latch = 1'b1;
                cnt_d     = disp_len - 1'b1;
                state_d   = DISPLAY;
            end
            DISPLAY: begin
                oe_n = 1'b0;
                if (cnt == '0) begin
                    bp_d = last_plane ? '0 : bp + 1'b1;
                    if (last_plane) begin
                        scan_row_d = last_row ? 4'd0 : scan_row + 4'd1;
                    end
                    frame_done = last_plane && last_row;
                    state_d    = enable ? SHIFT : IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign column_addr = col;
    assign bitplane    = bp;
    assign row_addr    = row_q;

endmodule

// File: tb/tb_matrix_scan_sched.sv
// tb_matrix_scan_sched: self-checking bench for matrix_scan_sched.
// Small 4x2 panel, 2 bit-planes, base 8 ticks; SCAN_DIM_EN optional.

module tb_matrix_scan_sched;

    localparam int W    = 4;
    localparam int HH   = 2;
    localparam int BB   = 2;
    localparam int BASE = 8;
    localparam int SL   = 2 * W;
`ifdef SCAN_DIM_EN
    localparam int DIMV = 2;
`else
    localparam int DIMV = 0;
`endif

    logic       clk = 1'b0;
    logic       rstb;
    logic       enable;
    logic [1:0] column_addr;
    logic       rd_en;
    logic [0:0] bitplane;
    logic [3:0] row_addr;
    logic       clk_pixel;
    logic       row_latch;
    logic       oe_n;
    logic       frame_done;
`ifdef SCAN_DIM_EN
    logic [1:0] dim;
`endif

    matrix_scan_sched #(
        .PIXEL_WIDTH     (W),
        .PIXEL_HALFHEIGHT(HH),
        .BRIGHTNESS_BITS (BB),
        .OE_BASE_TICKS   (BASE)
    ) dut (
        .clk_in     (clk),
        .rstb       (rstb),
        .enable     (enable),
        .column_addr(column_addr),
        .rd_en      (rd_en),
        .bitplane   (bitplane),
        .row_addr   (row_addr),
        .clk_pixel  (clk_pixel),
        .row_latch  (row_latch),
        .oe_n       (oe_n),
        .frame_done (frame_done)
`ifdef SCAN_DIM_EN
        ,
        .dim        (dim)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int plane;
        int row;
        int period;
    } disp_t;

    typedef struct {
        int plane;
        int row;
        int base_len;
    } vec_t;

    disp_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: each completed oe_n-low run is matched to the next
    // expected {plane, row, period}.
    int run     = 0;
    int lat_row = 0;
    int lat_pl  = 0;
    always @(negedge clk) begin
        disp_t e;
        if (row_latch) begin
            lat_row = int'(row_addr);
            lat_pl  = int'(bitplane);
        end
        if (!oe_n) begin
            run++;
        end else if (run > 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_display", run, 0);
            end else begin
                e = exp_q.pop_front();
                chk("oe_period", run, e.period);
                chk("latch_row", lat_row, e.row);
                chk("latch_plane", lat_pl, e.plane);
            end
            run = 0;
        end
        latch_vs_oe: assert (!(row_latch && !oe_n)) else begin
            errors++;
            $display("FAIL latch_oe_overlap: row_latch=%0b oe_n=%0b", row_latch, oe_n);
        end
    end

    task automatic trace_chk(input int k, input int p0);
        int e_rd, e_ck, e_col, e_lat, e_oe;
        e_rd = 0; e_ck = 0; e_col = 0; e_lat = 0; e_oe = 1;
        if (k <= SL) begin
            e_rd  = k % 2;
            e_ck  = 1 - e_rd;
            e_col = (k - 1) / 2;
        end else if (k == SL + 1) begin
            chk("blank_row_addr", int'(row_addr), 0);
        end else if (k == SL + 2) begin
            e_lat = 1;
        end else if (k <= SL + 2 + p0) begin
            e_oe = 0;
        end else begin
            e_rd = 1;
        end
        chk($sformatf("trace%0d_rd_en", k), int'(rd_en), e_rd);
        chk($sformatf("trace%0d_clk_pixel", k), int'(clk_pixel), e_ck);
        chk($sformatf("trace%0d_row_latch", k), int'(row_latch), e_lat);
        chk($sformatf("trace%0d_oe_n", k), int'(oe_n), e_oe);
        if (e_rd == 1) chk($sformatf("trace%0d_col", k), int'(column_addr), e_col);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_oe_n"}, int'(oe_n), 1);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_clk_pixel"}, int'(clk_pixel), 0);
        chk({tag, "_row_latch"}, int'(row_latch), 0);
        chk({tag, "_col"}, int'(column_addr), 0);
        chk({tag, "_bitplane"}, int'(bitplane), 0);
        chk({tag, "_row_addr"}, int'(row_addr), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  frame_tbl[4];
        disp_t d;
        int    p0, p1, fd_exp, fd_at, end_c, tick;
        int    rd_p1, late_rd, late_oe, fd_c;

        frame_tbl[0] = '{plane: 0, row: 0, base_len: 8};
        frame_tbl[1] = '{plane: 1, row: 0, base_len: 16};
        frame_tbl[2] = '{plane: 0, row: 1, base_len: 8};
        frame_tbl[3] = '{plane: 1, row: 1, base_len: 16};
        p0   = 8 >> DIMV;
        p1   = 16 >> DIMV;
        tick = (p0 > 5) ? 5 : p0 - 1;

        rstb   = 1'b0;
        enable = 1'b0;
`ifdef SCAN_DIM_EN
        dim = 2'(DIMV);
`endif
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rstb = 1'b1;
        @(negedge clk);
        chk("idle_no_rd_en", int'(rd_en), 0);

        // One full frame with enable held.
        fd_exp = 0;
        for (int i = 0; i < 4; i++) begin
            d.plane  = frame_tbl[i].plane;
            d.row    = frame_tbl[i].row;
            d.period = frame_tbl[i].base_len >> DIMV;
            exp_q.push_back(d);
            fd_exp += SL + 2 + d.period;
        end
        enable = 1'b1;
        fd_at  = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k <= SL + 3 + p0) trace_chk(k, p0);
            if (frame_done) begin
                fd_at = k;
                break;
            end
        end
        chk("frame_done_cycle", fd_at, fd_exp);

        // Drop enable mid-SHIFT of plane 1: block runs to end of its DISPLAY.
        exp_q.push_back('{plane: 0, row: 0, period: p0});
        exp_q.push_back('{plane: 1, row: 0, period: p1});
        end_c   = 2 * (SL + 2) + p0 + p1;
        rd_p1   = 0;
        late_rd = 0;
        late_oe = 0;
        fd_c    = 0;
        for (int k = 1; k <= end_c + 20; k++) begin
            @(negedge clk);
            if (k == 1) chk("frame_done_width", int'(frame_done), 0);
            if (k > SL + 2 + p0 && k <= 2 * SL + 2 + p0 && rd_en) rd_p1++;
            if (k > end_c) begin
                if (rd_en) late_rd++;
                if (!oe_n) late_oe++;
            end
            if (frame_done) fd_c++;
            if (k == SL + 2 + p0 + 3) enable = 1'b0;
        end
        chk("drop_plane1_reads", rd_p1, W);
        chk("drop_late_rd_en", late_rd, 0);
        chk("drop_late_oe", late_oe, 0);
        chk("drop_frame_done", fd_c, 0);
        chk("drop_queue_left", exp_q.size(), 0);

        // Restart keeps plane/row, then reset lands mid-DISPLAY.
        exp_q.push_back('{plane: 0, row: 1, period: tick});
        enable = 1'b1;
        for (int k = 1; k <= SL + 2 + tick; k++) begin
            @(negedge clk);
        end
        chk("pre_reset_in_display", int'(oe_n), 0);
        rstb = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_disp_rst");
        @(negedge clk);
        chk("rst_over_enable", int'(rd_en), 0);
        exp_q.push_back('{plane: 0, row: 0, period: p0});
        rstb = 1'b1;
        @(negedge clk);
        chk("restart_rd_en", int'(rd_en), 1);
        chk("restart_col", int'(column_addr), 0);
        enable = 1'b0;
        repeat (SL + 2 + p0 + 10) @(negedge clk);
        chk("final_idle_oe_n", int'(oe_n), 1);
        chk("final_queue_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_scan_sched.md
MATRIX_SCAN_SCHED -- requirements
Module: matrix_scan_sched

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 64, meaning columns shifted per row.
REQ-002 SHALL have parameter PIXEL_HALFHEIGHT, default 16, meaning rows per scan half, which is also the row_addr range.
REQ-003 SHALL have parameter BRIGHTNESS_BITS, default 4, meaning the number of BCM bit-planes.
REQ-004 SHALL have parameter OE_BASE_TICKS, default 16, meaning display cycles for bit-plane 0; legal minimum is 8.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rstb, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port enable, input, 1 bit: run the scan while high.
REQ-008 SHALL have port column_addr, output, $clog2(PIXEL_WIDTH) bits: framebuffer column read address.
REQ-009 SHALL have port rd_en, output, 1 bit: framebuffer read strobe; data returns 1 cycle later.
REQ-010 SHALL have port bitplane, output, $clog2(BRIGHTNESS_BITS) bits: current BCM plane, which selects the data bit.
REQ-011 SHALL have port row_addr, output, 4 bits: panel ROA[3:0].
REQ-012 SHALL have port clk_pixel, output, 1 bit: panel shift clock.
REQ-013 SHALL have port row_latch, output, 1 bit: panel latch.
REQ-014 SHALL have port oe_n, output, 1 bit: panel output enable, active-low.
REQ-015 SHALL have port frame_done, output, 1 bit: 1-cycle pulse at the end of each frame.

Function
REQ-016 SHALL implement the states IDLE, SHIFT, BLANK, LATCH and DISPLAY.
REQ-017 IDLE: when enable=1, SHALL go to SHIFT the next cycle with column 0, bitplane and scan row unchanged.
REQ-018 SHIFT: SHALL use 2 cycles per column.
  - Phase 0: clk_pixel=0, rd_en=1, column_addr=c.
  - Phase 1: clk_pixel=1, rd_en=0.
REQ-019 SHIFT: after phase 1 of column PIXEL_WIDTH-1, SHALL go to BLANK; total SHIFT length is 2*PIXEL_WIDTH cycles.
REQ-020 BLANK: SHALL hold oe_n=1 for 1 cycle and update row_addr to the scan row on entry to this state.
REQ-021 LATCH: SHALL drive row_latch=1 for exactly 1 cycle with oe_n=1, then go to DISPLAY.
REQ-022 DISPLAY: SHALL drive oe_n=0 for (OE_BASE_TICKS << bitplane) >> dim cycles, then advance:
  - bitplane+1;
  - on bitplane wrap from BRIGHTNESS_BITS-1 to 0, scan row+1;
  - on row wrap from PIXEL_HALFHEIGHT-1 to 0, frame_done=1 on the final DISPLAY cycle.
REQ-023 After DISPLAY, SHALL go to SHIFT if enable=1, else to IDLE.
REQ-024 enable deassertion in any non-IDLE state SHALL NOT abort the state; the block completes through the current DISPLAY.
REQ-025 Outside DISPLAY, oe_n SHALL be 1.
REQ-026 row_latch SHALL be 0 outside LATCH.
REQ-027 rd_en SHALL be 0 outside SHIFT phase 0.
REQ-028 The display counter SHALL be wide enough for OE_BASE_TICKS << (BRIGHTNESS_BITS-1) without overflow.
REQ-029 Any parameter combination whose display count computes to 0 SHALL be prohibited.

Reset
REQ-030 rstb=0 at a clock edge SHALL, from any state including mid-SHIFT or mid-DISPLAY, set on the next edge: state=IDLE, column_addr=0, bitplane=0, row_addr=0, scan row=0, clk_pixel=0, rd_en=0, row_latch=0, oe_n=1, frame_done=0.
REQ-031 rstb SHALL take precedence over enable.

Configuration
REQ-032 Macro SCAN_DIM_EN: when defined, SHALL add input dim[1:0], sampled only on entry to DISPLAY, with the duration per REQ-022.
REQ-033 When SCAN_DIM_EN is undefined, port dim SHALL be absent and dim SHALL be treated as 0.

Verification (PIXEL_WIDTH=4, PIXEL_HALFHEIGHT=2, BRIGHTNESS_BITS=2, OE_BASE_TICKS=8)
REQ-034 Reset, then enable=1 held, run one bit-plane -> 8 clk_pixel phases (4 rising edges), column_addr 0,1,2,3 with rd_en, 1 BLANK cycle, row_latch high 1 cycle, oe_n low 8 cycles.
REQ-035 Continuous enable for one full frame -> oe_n low periods 8,16,8,16.
  - row_addr 0,0,1,1 at each latch.
  - frame_done single pulse at cycle 2*(8+1+1+8)+2*(8+1+1+16)=88 after leaving IDLE.
REQ-036 Drop enable mid-SHIFT of plane 1 -> the sequence completes through the 16-cycle DISPLAY, then IDLE with oe_n=1 and no further rd_en.
REQ-037 rstb=0 asserted during DISPLAY at tick 5 -> next cycle oe_n=1, all counters 0, IDLE; re-enable restarts at row 0, plane 0.
REQ-038 SCAN_DIM_EN defined, dim=2 -> oe_n low periods 2 and 4 per plane.
REQ-039 Throughout every scenario, an assertion SHALL check that row_latch and oe_n=0 are never simultaneous.
